uproc_control_fsm: RTL

//  Fetch/execute controller for the 4-bit nibble processor. Owns PC, IR and the
//  C/Z flags, and sequences the 4-bit ALU (f: 000 pass_a, 001 compare,
//  010 pass_b, 011 ADD, 100 NOR).

---
 rtl/uproc_pkg.sv | 51 +++++
 rtl/uproc_decode.sv | 37 +++
 rtl/uproc_control_fsm.sv | 82 ++++++++
 3 files changed

// File: rtl/uproc_pkg.sv
// Shared encodings for the nibble processor: opcodes, ALU functions, B-mux selects,
// controller phase and the decoded control bundle.
package uproc_pkg;

  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_JNC  = 4'h1;
  localparam logic [3:0] OP_CMPI = 4'h2;
  localparam logic [3:0] OP_CMPM = 4'h3;
  localparam logic [3:0] OP_LIT  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_ADDM = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_NORI = 4'hC;
  localparam logic [3:0] OP_NORM = 4'hD;
  localparam logic [3:0] OP_ST   = 4'hE;
  localparam logic [3:0] OP_JNZ  = 4'hF;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_CMP    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NOR    = 3'b100;

  localparam logic [1:0] BSEL_IMM = 2'b00;
  localparam logic [1:0] BSEL_RAM = 2'b01;
  localparam logic [1:0] BSEL_IN  = 2'b10;

  // EXEC and JADDR share one encoding; the opcode in ir tells them apart.
  localparam logic [0:0] PH_FETCH = 1'b0;
  localparam logic [0:0] PH_EXEC  = 1'b1;

  typedef struct packed {
    logic [2:0] alu_f;
    logic [1:0] b_sel;
    logic       acc_we;
    logic       ram_we;
    logic       out_we;
    logic       c_upd;
    logic       z_upd;
  } ctrl_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JC) || (op == OP_JNC) || (op == OP_JZ) ||
           (op == OP_JMP) || (op == OP_JNZ);
  endfunction

endpackage

// File: rtl/uproc_decode.sv
// Combinational instruction decode: ir and phase to ALU select, B mux, write
// enables and flag-update masks. Everything is zero outside an EXEC cycle.
module uproc_decode
  import uproc_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       phase,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (phase == PH_EXEC) begin
      unique case (ir[7:4])
        OP_CMPI: begin ctrl.alu_f = ALU_CMP;    ctrl.b_sel = BSEL_IMM; ctrl.c_upd = 1'b1; end
        OP_CMPM: begin ctrl.alu_f = ALU_CMP;    ctrl.b_sel = BSEL_RAM; ctrl.c_upd = 1'b1; end
        OP_LIT:  begin ctrl.alu_f = ALU_PASS_B; ctrl.b_sel = BSEL_IMM; ctrl.acc_we = 1'b1; ctrl.z_upd = 1'b1; end
        OP_IN:   begin ctrl.alu_f = ALU_PASS_B; ctrl.b_sel = BSEL_IN;  ctrl.acc_we = 1'b1; ctrl.z_upd = 1'b1; end
        OP_LD:   begin ctrl.alu_f = ALU_PASS_B; ctrl.b_sel = BSEL_RAM; ctrl.acc_we = 1'b1; ctrl.z_upd = 1'b1; end
        OP_ADDI: begin
          ctrl.alu_f = ALU_ADD; ctrl.b_sel = BSEL_IMM; ctrl.acc_we = 1'b1;
          ctrl.c_upd = 1'b1;    ctrl.z_upd = 1'b1;
        end
        OP_ADDM: begin
          ctrl.alu_f = ALU_ADD; ctrl.b_sel = BSEL_RAM; ctrl.acc_we = 1'b1;
          ctrl.c_upd = 1'b1;    ctrl.z_upd = 1'b1;
        end
        OP_OUT:  begin ctrl.alu_f = ALU_PASS_A; ctrl.out_we = 1'b1; end
        OP_NORI: begin ctrl.alu_f = ALU_NOR;    ctrl.b_sel = BSEL_IMM; ctrl.acc_we = 1'b1; ctrl.z_upd = 1'b1; end
        OP_NORM: begin ctrl.alu_f = ALU_NOR;    ctrl.b_sel = BSEL_RAM; ctrl.acc_we = 1'b1; ctrl.z_upd = 1'b1; end
        OP_ST:   begin ctrl.alu_f = ALU_PASS_A; ctrl.ram_we = 1'b1; end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/uproc_control_fsm.sv
// Two-clock fetch/execute controller for the nibble processor: owns PC, IR and
// the C/Z flags; the datapath enables come straight out of the decoder.
module uproc_control_fsm
  import uproc_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [7:0]      prog_byte,
  input  logic            alu_c_out,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic [2:0]      alu_f,
  output logic [1:0]      b_sel,
  output logic [3:0]      operand,
  output logic            acc_we,
  output logic            ram_we,
  output logic            out_we,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            phase
);

  ctrl_t           ctrl;
  logic            take;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_tgt;

  uproc_decode u_dec (
    .ir    (ir),
    .phase (phase),
    .ctrl  (ctrl)
  );

  // Decode depends only on registers, so async reset clears the enables at once.
  assign alu_f   = ctrl.alu_f;
  assign b_sel   = ctrl.b_sel;
  assign acc_we  = ctrl.acc_we;
  assign ram_we  = ctrl.ram_we;
  assign out_we  = ctrl.out_we;
  assign operand = ir[3:0];

  assign pc_inc  = pc + PC_W'(1);
  assign jmp_tgt = PC_W'({ir[3:0], prog_byte});

  always_comb begin
    unique case (ir[7:4])
      OP_JC:   take = carry_flag;
      OP_JNC:  take = ~carry_flag;
      OP_JZ:   take = zero_flag;
      OP_JNZ:  take = ~zero_flag;
      OP_JMP:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      ir         <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      phase      <= PH_FETCH;
    end else if (phase == PH_FETCH) begin
      if (run) begin
        ir    <= prog_byte;
        pc    <= pc_inc;
        phase <= PH_EXEC;
      end
    end else begin
      phase <= PH_FETCH;
      if (is_jump(ir[7:4])) pc <= take ? jmp_tgt : pc_inc;
      if (ctrl.c_upd) carry_flag <= alu_c_out;
      if (ctrl.z_upd) zero_flag  <= alu_zero;
    end
  end

endmodule
